// File: rtl/tmul_fp16_a_skew_feeder.sv
// A-row feeder for the 16-stage FP16 TMUL row pipeline: diagonal lane skew,
// tile sequencing, B-lock and result tagging.
module tmul_fp16_a_skew_feeder #(
    parameter int LANES = 16,
    parameter int DW    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [4:0]            num_rows_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [LANES*DW-1:0]   a_row_i,
    output logic [DW-1:0]         row_a_skew_o [LANES],
    output logic                  b_lock_o,
    output logic                  busy_o,
    output logic                  out_valid_o,
    output logic [3:0]            out_row_idx_o,
    output logic                  tile_done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE0  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  n_q, n_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  cnt_inc;
    logic        accept;
    logic        head_last;
    logic        tile_done;

    logic        tv_q [LANES];
    logic [3:0]  ti_q [LANES];

    assign accept    = a_valid_i && (state_q == STREAM);
    assign cnt_inc   = cnt_q + 5'd1;
    assign head_last = tv_q[LANES-1] &&
                       ({1'b0, ti_q[LANES-1]} + 5'd1 == n_q);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        tile_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_d   = (num_rows_i > 5'd16) ? 5'd16 : num_rows_i;
                    cnt_d = '0;
                    state_d = (num_rows_i == 5'd0) ? DONE0 : STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (head_last) begin
                    tile_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            DONE0: begin
                // counter doubles as a one-cycle delay before the empty-tile pulse
                if (cnt_q[0]) begin
                    tile_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane k: (k+1)-deep chain, bubbles enter as zero
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DW-1:0] pipe_q [k+1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j <= k; j++) pipe_q[j] <= '0;
            end else begin
                pipe_q[0] <= accept ? a_row_i[k*DW +: DW] : '0;
                for (int j = 1; j <= k; j++) pipe_q[j] <= pipe_q[j-1];
            end
        end

        assign row_a_skew_o[k] = pipe_q[k];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < LANES; j++) begin
                tv_q[j] <= 1'b0;
                ti_q[j] <= '0;
            end
        end else begin
            tv_q[0] <= accept;
            ti_q[0] <= accept ? cnt_q[3:0] : 4'd0;
            for (int j = 1; j < LANES; j++) begin
                tv_q[j] <= tv_q[j-1];
                ti_q[j] <= ti_q[j-1];
            end
        end
    end

    assign a_ready_o     = (state_q == STREAM);
    assign b_lock_o      = (state_q == STREAM) || (state_q == DRAIN);
    assign busy_o        = (state_q != IDLE);
    assign out_valid_o   = tv_q[LANES-1];
    assign out_row_idx_o = ti_q[LANES-1];
    assign tile_done_o   = tile_done;

endmodule

// File: tb/tb_tmul_fp16_a_skew_feeder.sv
// Randomized bench for tmul_fp16_a_skew_feeder against a timeline model
// built from accept timestamps.
module tb_tmul_fp16_a_skew_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [4:0]   num_rows;
    logic         a_valid;
    logic         a_ready;
    logic [255:0] a_row;
    logic [15:0]  row_a_skew [16];
    logic         b_lock;
    logic         busy;
    logic         out_valid;
    logic [3:0]   out_row_idx;
    logic         tile_done;

    tmul_fp16_a_skew_feeder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .num_rows_i    (num_rows),
        .a_valid_i     (a_valid),
        .a_ready_o     (a_ready),
        .a_row_i       (a_row),
        .row_a_skew_o  (row_a_skew),
        .b_lock_o      (b_lock),
        .busy_o        (busy),
        .out_valid_o   (out_valid),
        .out_row_idx_o (out_row_idx),
        .tile_done_o   (tile_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    // Timeline model: accepts recorded by edge number in a ring
    int           cyc;
    bit           acc_v    [64];
    bit           acc_last [64];
    logic [3:0]   acc_idx  [64];
    logic [255:0] acc_row  [64];
    bit           m_tile;
    int           m_n, m_acc, m_S, m_L, done0_at;

    function automatic bit busy_exp();
        if (!m_tile) return 1'b0;
        if (m_n == 0) return cyc < m_S + 2;
        return (m_acc < m_n) || (cyc < m_L + 16);
    endfunction

    function automatic bit ready_exp();
        return m_tile && (m_acc < m_n);
    endfunction

    function automatic bit rec_v(int e);
        if (e < 0) return 1'b0;
        return acc_v[e & 63];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            acc_v[i] = 0; acc_last[i] = 0;
            acc_idx[i] = '0; acc_row[i] = '0;
        end
        m_tile = 0; m_n = 0; m_acc = 0;
        m_S = -100; m_L = -100; done0_at = -100;
    endtask

    task automatic check_outputs();
        logic [255:0] got_l, exp_l;
        int e15;
        bit ov, td;
        for (int k = 0; k < 16; k++) begin
            got_l[16*k +: 16] = row_a_skew[k];
            exp_l[16*k +: 16] = rec_v(cyc - k) ?
                acc_row[(cyc - k) & 63][16*k +: 16] : 16'h0000;
        end
        e15 = cyc - 15;
        ov  = rec_v(e15);
        td  = (cyc == done0_at) || (ov && acc_last[e15 & 63]);
        check("lanes", got_l, exp_l);
        check("a_ready", 256'(a_ready), 256'(ready_exp()));
        check("busy", 256'(busy), 256'(busy_exp()));
        check("b_lock", 256'(b_lock), 256'(busy_exp() && m_n != 0));
        check("out_valid", 256'(out_valid), 256'(ov));
        if (ov) check("out_row_idx", 256'(out_row_idx), 256'(acc_idx[e15 & 63]));
        check("tile_done", 256'(tile_done), 256'(td));
    endtask

    task automatic step(bit st, int nr, bit av, logic [255:0] row);
        int e;
        bit rdy, idle, acc;
        e    = cyc + 1;
        rdy  = ready_exp();
        idle = !busy_exp();
        start = st; num_rows = nr[4:0]; a_valid = av; a_row = row;
        acc = rdy && av && rst_n;
        acc_v[e & 63]    = acc;
        acc_row[e & 63]  = acc ? row : '0;
        acc_idx[e & 63]  = m_acc[3:0];
        acc_last[e & 63] = acc && (m_acc + 1 == m_n);
        if (acc) begin
            m_acc++;
            if (m_acc == m_n) m_L = e;
        end
        if (rst_n && idle && st) begin
            m_tile = 1;
            m_n    = (nr > 16) ? 16 : nr;
            m_acc  = 0;
            m_S    = e;
            if (m_n == 0) done0_at = e + 1;
        end
        @(posedge clk);
        cyc = e;
        #1;
        check_outputs();
    endtask

    function automatic logic [255:0] make_row(int kind, int r);
        logic [255:0] v;
        logic [3:0]   r4, k4;
        for (int k = 0; k < 16; k++) begin
            r4 = r[3:0]; k4 = k[3:0];
            case (kind)
                0:       v[16*k +: 16] = 16'h3C00 + 16'(k);
                1:       v[16*k +: 16] = {r4, k4, 8'h00};
                default: v[16*k +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic feed(int pct, int kind, bit noise);
        int guard = 0;
        while (m_tile && m_acc < m_n && guard < 400) begin
            guard++;
            step(noise && $urandom_range(1) == 1, 3,
                 $urandom_range(99) < pct, make_row(kind, m_acc));
        end
        if (m_acc < m_n) check("feed_timeout", 256'(m_acc), 256'(m_n));
    endtask

    task automatic drain(bit noise);
        int guard = 0;
        while (busy_exp() && guard < 40) begin
            guard++;
            step(noise && $urandom_range(1) == 1, 3, 1'b0, make_row(2, 0));
        end
        if (busy_exp()) check("drain_timeout", 256'(busy_exp()), 256'(0));
    endtask

    initial begin
        bit tog [7] = '{1, 0, 0, 1, 1, 0, 1};
        rst_n = 1; start = 0; a_valid = 0; num_rows = 0; a_row = '0;
        cyc = 0;
        model_reset();
        #1 rst_n = 0;
        #1 check_outputs();
        repeat (3) step(1, 5, 1, make_row(2, 0));
        rst_n = 1;
        repeat (2) step(0, 0, 0, '0);

        // single row
        step(1, 1, 0, '0);
        step(0, 0, 1, make_row(0, 0));
        drain(0);

        // 16 back-to-back
        step(1, 16, 0, '0);
        feed(100, 1, 0);
        drain(0);

        // bubbles in the accept stream
        step(1, 4, 0, '0);
        for (int i = 0; i < 7; i++) step(0, 0, tog[i], make_row(1, m_acc));
        feed(100, 1, 0);
        drain(0);

        // start noise during STREAM and DRAIN
        step(1, 5, 0, '0);
        feed(70, 2, 1);
        drain(1);

        // empty tile, then saturated tile
        step(1, 0, 0, '0);
        drain(0);
        step(0, 0, 0, '0);
        step(1, 20, 0, '0);
        feed(100, 2, 0);
        drain(0);

        repeat (12) begin
            step(1, $urandom_range(31), 0, '0);
            feed($urandom_range(40, 100), 2, 1);
            drain(1);
            repeat ($urandom_range(2)) step(0, 0, 1, make_row(2, 0));
        end

        // asynchronous reset in DRAIN
        step(1, 6, 0, '0);
        feed(100, 2, 0);
        repeat (5) step(0, 0, 0, '0);
        #2 rst_n = 0;
        model_reset();
        #1 check_outputs();
        repeat (2) step(0, 0, 1, make_row(2, 0));
        rst_n = 1;
        repeat (20) step(0, 0, 0, '0);
        step(1, 2, 0, '0);
        feed(100, 2, 0);
        drain(0);
        step(0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
